// File: rtl/mul_div_unit_if.sv
// Bus between the EX stage and the HI/LO multiply/divide unit.
// The unit is the slave. The pipeline (or a testbench) is the master.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_a;      // rs operand, also mthi/mtlo data
  logic [WIDTH-1:0] i_b;      // rt operand
  logic [2:0]       i_op;     // 0 mult .. 7 msubu
  logic             i_start;  // launch i_op with i_a/i_b
  logic [1:0]       i_write;  // 1 mthi, 2 mtlo, else none
  logic             i_cancel; // pipeline flush
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_busy;
  logic             o_done;

  modport slave (
    input  i_a, i_b, i_op, i_start, i_write, i_cancel,
    output o_hi, o_lo, o_busy, o_done
  );

  modport master (
    output i_a, i_b, i_op, i_start, i_write, i_cancel,
    input  o_hi, o_lo, o_busy, o_done
  );
endinterface

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit.
// Multiply ops register the full product at Start and commit it after MUL_LAT edges.
// The commit can replace, add to or subtract from {HI,LO}.
// Divide ops run a restoring divider that produces one quotient bit per edge.
// A final FIX edge then applies sign correction and the divide-by-zero result.
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  // Op[2:1] selects the operation kind. Op[0]=1 means unsigned.
  localparam logic [1:0] K_MULT = 2'b00;
  localparam logic [1:0] K_DIV  = 2'b01;
  localparam logic [1:0] K_MADD = 2'b10;
  localparam logic [1:0] K_MSUB = 2'b11;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_kind;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_a;      // original dividend, used as HI on divide-by-zero
  logic [WIDTH-1:0]   r_quo;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_div;    // divisor magnitude
  logic               r_b_zero;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  // Operand conditioning at the Start edge.
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_signed  = ~bus.i_op[0];
  assign w_a_neg   = w_signed & bus.i_a[WIDTH-1];
  assign w_b_neg   = w_signed & bus.i_b[WIDTH-1];
  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
  // The result is taken mod 2^(2*WIDTH).
  assign w_a_ext   = {{WIDTH{w_a_neg}}, bus.i_a};
  assign w_b_ext   = {{WIDTH{w_b_neg}}, bus.i_b};
  assign w_product = w_a_ext * w_b_ext;
  // Negating the most negative value wraps to itself.
  // As an unsigned magnitude that is still the correct 2^(WIDTH-1).
  assign w_a_mag   = w_a_neg ? -bus.i_a : bus.i_a;
  assign w_b_mag   = w_b_neg ? -bus.i_b : bus.i_b;

  // One restoring step: shift in the next dividend bit, then subtract if it fits.
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  // When the subtraction is taken, the true difference is below the divisor.
  // So the low WIDTH bits carry the whole result.
  assign w_rem_nxt = w_ge ? (w_rem_sh[WIDTH-1:0] - r_div) : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;

  assign w_quo_fin = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fin = r_neg_r ? -r_rem : r_rem;

  // Multiply commit value: plain product, or accumulated into {HI,LO}.
  logic [2*WIDTH-1:0] w_mul_res;

  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred latches.
    w_mul_res = r_prod;
    case (r_kind)
      K_MADD:  w_mul_res = {r_hi, r_lo} + r_prod;
      K_MSUB:  w_mul_res = {r_hi, r_lo} - r_prod;
      default: w_mul_res = r_prod;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: non-blocking assignments here, so every register samples pre-edge values.
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_kind   <= K_MULT;
      r_prod   <= '0;
      r_a      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_b_zero <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.i_cancel) begin
        // Flush: drop the in-flight op and any same-cycle Start/Write.
        // HI/LO are untouched.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.i_write == 2'b01) begin
              r_hi <= bus.i_a;
            end else if (bus.i_write == 2'b10) begin
              r_lo <= bus.i_a;
            end else if (bus.i_start) begin
              r_kind   <= bus.i_op[2:1];
              r_prod   <= w_product;
              r_a      <= bus.i_a;
              r_quo    <= w_a_mag;
              r_rem    <= '0;
              r_div    <= w_b_mag;
              r_b_zero <= (bus.i_b == '0);
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_busy   <= 1'b1;
              if (bus.i_op[2:1] == K_DIV) begin
                r_state <= S_DIV;
                r_cnt   <= '0;
              end else begin
                r_state <= S_MUL;
                r_cnt   <= CNT_W'(1);
              end
            end
          end
          S_MUL: begin
            if (r_cnt == MUL_LAST) begin
              {r_hi, r_lo} <= w_mul_res;
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_DIV: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == DIV_LAST) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_FIX: begin
            if (r_b_zero) begin
              r_lo <= '1;
              r_hi <= r_a;
            end else begin
              r_lo <= w_quo_fin;
              r_hi <= w_rem_fin;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard testbench for mul_div_unit.
// The stimulus pushes the expected HI/LO and latency for each launched op.
// A monitor pops and compares on every Done pulse.
// A second instance covers WIDTH=8, MUL_LAT=1.
module tb_mul_div_unit;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit_if #(.WIDTH(W)) bus ();
  mul_div_unit_if #(.WIDTH(8)) bus8 ();

  mul_div_unit #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  mul_div_unit #(.WIDTH(8), .MUL_LAT(1)) dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus8.slave)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the 32-bit operands.
  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, b,
                                 input logic [W-1:0] hi, lo,
                                 output logic [W-1:0] nhi, nlo);
    longint       sa, sb, q, r;
    logic [63:0]  qv, rv, p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'd2 || op == 3'd3) begin
      if (b == '0) begin
        nlo = '1;
        nhi = a;
      end else if (op == 3'd2) begin
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        nlo = qv[31:0];
        nhi = rv[31:0];
      end else begin
        qv = {32'd0, a} / {32'd0, b};
        rv = {32'd0, a} % {32'd0, b};
        nlo = qv[31:0];
        nhi = rv[31:0];
      end
    end else begin
      if (op[0] == 1'b0) p = sa * sb;
      else               p = {32'd0, a} * {32'd0, b};
      acc = {hi, lo};
      if (op == 3'd4 || op == 3'd5)      acc = acc + p;
      else if (op == 3'd6 || op == 3'd7) acc = acc - p;
      else                               acc = p;
      nhi = acc[63:32];
      nlo = acc[31:0];
    end
  endfunction

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(bus.o_done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_hi", 64'(bus.o_hi), 64'(e.hi));
        check("done_lo", 64'(bus.o_lo), 64'(e.lo));
        check("done_latency", 64'(cyc - e.cyc), 64'(e.lat));
      end
    end
  end

  // All tasks are entered just after a falling edge.
  task automatic write_reg(input logic [1:0] w, input logic [W-1:0] a);
    bus.i_write = w;
    bus.i_a     = a;
    @(negedge clk);
    bus.i_write = 2'd0;
    if (w == 2'd1) model_hi = a;
    if (w == 2'd2) model_lo = a;
    check("write_hi", 64'(bus.o_hi), 64'(model_hi));
    check("write_lo", 64'(bus.o_lo), 64'(model_lo));
  endtask

  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, b);
    exp_t e;
    logic [W-1:0] nhi, nlo;
    ref_op(op, a, b, model_hi, model_lo, nhi, nlo);
    e.hi  = nhi;
    e.lo  = nlo;
    e.lat = (op == 3'd2 || op == 3'd3) ? DIV_LAT : MUL_LAT;
    e.cyc = cyc + 1;
    sb_q.push_back(e);
    model_hi = nhi;
    model_lo = nlo;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (bus.o_done) seen = 1'b1;
      else begin
        if (bus.o_busy) busy_cnt++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no Done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b);
    int lat, bc;
    lat = (op == 3'd2 || op == 3'd3) ? DIV_LAT : MUL_LAT;
    start_op(op, a, b);
    wait_done(lat + 4, bc);
    check("busy_cycles", 64'(bc), 64'(lat));
    check("busy_low_at_done", 64'(bus.o_busy), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] pre_hi, pre_lo;
    int           bc;

    bus.i_a = '0;  bus.i_b = '0;  bus.i_op = '0;
    bus.i_start = 1'b0;  bus.i_write = '0;  bus.i_cancel = 1'b0;
    bus8.i_a = '0; bus8.i_b = '0; bus8.i_op = '0;
    bus8.i_start = 1'b0; bus8.i_write = '0; bus8.i_cancel = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_hi", 64'(bus.o_hi), 64'd0);
    check("rst_lo", 64'(bus.o_lo), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Signed multiply of -3 by 7, with known HI/LO values.
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("t1_hi", 64'(bus.o_hi), 64'hFFFF_FFFF);
    check("t1_lo", 64'(bus.o_lo), 64'hFFFF_FFEB);

    // Divides, including divide-by-zero and signed overflow.
    run_op(3'd3, 32'd100, 32'd7);
    check("t2_divu_lo", 64'(bus.o_lo), 64'd14);
    check("t2_divu_hi", 64'(bus.o_hi), 64'd2);
    run_op(3'd2, -32'd7, 32'd2);
    check("t2_div_lo", 64'(bus.o_lo), 64'hFFFF_FFFD);
    check("t2_div_hi", 64'(bus.o_hi), 64'hFFFF_FFFF);
    run_op(3'd2, 32'd1234, 32'd0);
    check("t3_dz_lo", 64'(bus.o_lo), 64'hFFFF_FFFF);
    check("t3_dz_hi", 64'(bus.o_hi), 64'd1234);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("t3_ovf_lo", 64'(bus.o_lo), 64'h8000_0000);
    check("t3_ovf_hi", 64'(bus.o_hi), 64'd0);

    // Multiply-accumulate and multiply-subtract on preloaded HI/LO.
    @(negedge clk);
    write_reg(2'd1, 32'd1);
    write_reg(2'd2, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd1, 32'd1);
    check("t4_maddu_hi", 64'(bus.o_hi), 64'd2);
    check("t4_maddu_lo", 64'(bus.o_lo), 64'd0);
    run_op(3'd6, 32'd1, 32'd2);
    check("t4_msub_hi", 64'(bus.o_hi), 64'd1);
    check("t4_msub_lo", 64'(bus.o_lo), 64'hFFFF_FFFE);

    // Cancel a divide mid-flight: no Done, HI/LO unchanged.
    @(negedge clk);
    write_reg(2'd1, 32'h55);
    pre_lo = model_lo;
    bus.i_op = 3'd3; bus.i_a = 32'd100; bus.i_b = 32'd7; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    bus.i_cancel = 1'b1;
    @(negedge clk);
    bus.i_cancel = 1'b0;
    check("cancel_busy", 64'(bus.o_busy), 64'd0);
    check("cancel_hi", 64'(bus.o_hi), 64'h55);
    check("cancel_lo", 64'(bus.o_lo), 64'(pre_lo));
    repeat (DIV_LAT + 4) @(negedge clk);
    check("cancel_still_idle", 64'(bus.o_busy), 64'd0);

    // An mthi issued while Busy is ignored.
    pre_hi = model_hi;
    start_op(3'd3, 32'd100, 32'd7);
    bus.i_write = 2'd1; bus.i_a = 32'h99;
    @(negedge clk);
    bus.i_write = 2'd0;
    check("mthi_busy_hi", 64'(bus.o_hi), 64'(pre_hi));
    wait_done(DIV_LAT + 4, bc);

    // Start and Write in the same idle cycle: the Write wins and the Start is dropped.
    bus.i_write = 2'd2; bus.i_a = 32'hCAFE_F00D; bus.i_op = 3'd0; bus.i_b = 32'd3;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_write = 2'd0; bus.i_start = 1'b0;
    model_lo = 32'hCAFE_F00D;
    check("sw_busy", 64'(bus.o_busy), 64'd0);
    check("sw_lo", 64'(bus.o_lo), 64'hCAFE_F00D);
    repeat (MUL_LAT + 3) @(negedge clk);

    // Randomized mix of ops and writes.
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      write_reg(2'd1, rand_operand());
      else if (sel == 1) write_reg(2'd2, rand_operand());
      else               run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.i_op = 3'd2; bus.i_a = 32'd12345; bus.i_b = 32'd17; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hi", 64'(bus.o_hi), 64'd0);
    check("arst_lo", 64'(bus.o_lo), 64'd0);
    check("arst_busy", 64'(bus.o_busy), 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (DIV_LAT + 3) @(negedge clk);
    check("arst_no_done_busy", 64'(bus.o_busy), 64'd0);

    // Narrow instance: WIDTH=8, MUL_LAT=1.
    bus8.i_op = 3'd1; bus8.i_a = 8'hFF; bus8.i_b = 8'hFF; bus8.i_start = 1'b1;
    @(negedge clk);
    bus8.i_start = 1'b0;
    check("w8_busy", 64'(bus8.o_busy), 64'd1);
    @(negedge clk);
    check("w8_done", 64'(bus8.o_done), 64'd1);
    check("w8_hilo", 64'({bus8.o_hi, bus8.o_lo}), 64'hFE01);
    bus8.i_op = 3'd2; bus8.i_a = 8'h80; bus8.i_b = 8'hFF; bus8.i_start = 1'b1;
    @(negedge clk);
    bus8.i_start = 1'b0;
    repeat (8) @(negedge clk);
    check("w8_div_not_done", 64'(bus8.o_done), 64'd0);
    @(negedge clk);
    check("w8_div_done", 64'(bus8.o_done), 64'd1);
    check("w8_div_hilo", 64'({bus8.o_hi, bus8.o_lo}), 64'h0080);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("final_hi", 64'(bus.o_hi), 64'(model_hi));
    check("final_lo", 64'(bus.o_lo), 64'(model_lo));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog for the whole run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
